// File: rtl/key_schedule_rev_if.sv
// rtl/key_schedule_rev_if.sv - load/emit stream bundle for the reverse key generator
//
// Ports carried:
//   start     load request (master -> slave)
//   key_i     128-bit key, column 0 in [127:96] (master -> slave)
//   rk_ready  consumer accepts current round key (master -> slave)
//   busy      generator not idle (slave -> master)
//   rk_valid  rk_o/rk_round hold a valid round key (slave -> master)
//   rk_o      128-bit round key, same packing as key_i (slave -> master)
//   rk_round  round index of rk_o, 10 down to 0 (slave -> master)
interface key_schedule_rev_if;
   logic         start;
   logic [127:0] key_i;
   logic         rk_ready;
   logic         busy;
   logic         rk_valid;
   logic [127:0] rk_o;
   logic [3:0]   rk_round;

   modport master (
      output start, key_i, rk_ready,
      input  busy, rk_valid, rk_o, rk_round
   );

   modport slave (
      input  start, key_i, rk_ready,
      output busy, rk_valid, rk_o, rk_round
   );
endinterface

// File: rtl/key_schedule_rev.sv
// rtl/key_schedule_rev.sv - AES-128 decryption round-key generator (round 10 down to 0)
//
// Modules:
//   sub_word          four parallel AES S-boxes on a 32-bit word
//   rcon              round constant lookup, index 1..10
//   key_schedule_rev  top: clk_i-style scalar clk/rst plus bus (key_schedule_rev_if.slave)
//
// Top ports:
//   clk   system clock, rising edge
//   rst   asynchronous active-high reset
//   bus   start/key_i/rk_ready in; busy/rk_valid/rk_o/rk_round out
//
// Build option KEY_SCHED_LASTKEY_EN: key_i is taken as the round-10 key and
// emission starts right after load (no forward expansion).

module sub_word (
   input  logic [31:0] w_i,
   output logic [31:0] w_o
);
   // Index 0 is the most significant byte of the literal.
   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   assign w_o = {SBOX[w_i[31:24]], SBOX[w_i[23:16]], SBOX[w_i[15:8]], SBOX[w_i[7:0]]};
endmodule

module rcon (
   input  logic [7:0] idx_i,
   output logic [7:0] rc_o
);
   always_comb begin
      rc_o = 8'h00;
      case (idx_i)
         8'd1:    rc_o = 8'h01;
         8'd2:    rc_o = 8'h02;
         8'd3:    rc_o = 8'h04;
         8'd4:    rc_o = 8'h08;
         8'd5:    rc_o = 8'h10;
         8'd6:    rc_o = 8'h20;
         8'd7:    rc_o = 8'h40;
         8'd8:    rc_o = 8'h80;
         8'd9:    rc_o = 8'h1b;
         8'd10:   rc_o = 8'h36;
         default: rc_o = 8'h00;
      endcase
   end
endmodule

module key_schedule_rev #(
   parameter int NR = 10
) (
   input logic              clk,
   input logic              rst,
   key_schedule_rev_if.slave bus
);
   localparam logic [3:0] LAST = NR[3:0];

   typedef enum logic [1:0] {IDLE, EXPAND, EMIT} state_t;

   state_t       state_q, state_d;
   logic [127:0] key_q, key_d;
   logic [3:0]   cnt_q, cnt_d;

   logic [31:0]  w0, w1, w2, w3;
   logic [31:0]  p0, p1, p2, p3;
   logic [31:0]  f0, f1, f2, f3;
   logic [31:0]  sw_in, sw_out;
   logic [7:0]   rc_idx, rc_val;

   assign {w0, w1, w2, w3} = key_q;

   // Inverse step recovers the previous round's columns right to left;
   // only the new column 0 needs the S-box.
   assign p3 = w3 ^ w2;
   assign p2 = w2 ^ w1;
   assign p1 = w1 ^ w0;

`ifdef KEY_SCHED_LASTKEY_EN
   assign sw_in = p3;
`else
   assign sw_in = (state_q == EXPAND) ? w3 : p3;
`endif

   // Single S-box bank shared by both directions (RotWord applied first).
   sub_word u_sub_word (
      .w_i ({sw_in[23:0], sw_in[31:24]}),
      .w_o (sw_out)
   );

   // Expansion builds round cnt+1; the inverse step undoes round cnt.
   assign rc_idx = (state_q == EXPAND) ? {4'd0, cnt_q + 4'd1} : {4'd0, cnt_q};

   rcon u_rcon (
      .idx_i (rc_idx),
      .rc_o  (rc_val)
   );

   assign f0 = w0 ^ sw_out ^ {rc_val, 24'h0};
   assign f1 = w1 ^ f0;
   assign f2 = w2 ^ f1;
   assign f3 = w3 ^ f2;
   assign p0 = w0 ^ sw_out ^ {rc_val, 24'h0};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         key_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         key_q   <= key_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      key_d   = key_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               key_d = bus.key_i;
`ifdef KEY_SCHED_LASTKEY_EN
               cnt_d   = LAST;
               state_d = EMIT;
`else
               cnt_d   = 4'd0;
               state_d = EXPAND;
`endif
            end
         end
         EXPAND: begin
            key_d = {f0, f1, f2, f3};
            cnt_d = cnt_q + 4'd1;
            if (cnt_q + 4'd1 == LAST) begin
               state_d = EMIT;
            end
         end
         EMIT: begin
            if (bus.rk_ready) begin
               if (cnt_q == 4'd0) begin
                  state_d = IDLE;
               end else begin
                  key_d = {p0, p1, p2, p3};
                  cnt_d = cnt_q - 4'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs derive only from registers; outside EMIT they read as zero.
   assign bus.busy     = (state_q != IDLE);
   assign bus.rk_valid = (state_q == EMIT);
   assign bus.rk_o     = (state_q == EMIT) ? key_q : 128'h0;
   assign bus.rk_round = (state_q == EMIT) ? cnt_q : 4'd0;
endmodule

// File: tb/tb_key_schedule_rev.sv
// tb/tb_key_schedule_rev.sv - self-checking bench for key_schedule_rev
module tb_key_schedule_rev;
`ifdef KEY_SCHED_LASTKEY_EN
   localparam int LAT = 0;
`else
   localparam int LAT = 10;
`endif
   localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   key_schedule_rev_if bus();

   key_schedule_rev #(.NR(10)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int passed;
   int total;
   logic [7:0]   sbox_t  [0:255];
   logic [127:0] model_rk [0:10];
   logic [127:0] got_rk   [0:10];

   typedef struct {
      logic [127:0] key;
      int           round;
      logic [127:0] exp;
   } vec_t;
   vec_t vecs [0:4];

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h want %h", nm, act, exp);
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
      logic [7:0] a, b, p;
      a = a_in; b = b_in; p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
         b = b >> 1;
      end
      return p;
   endfunction

   // S-box from its definition: multiplicative inverse in GF(2^8) then affine map.
   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sbox_t[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                     ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      end
   endtask

   // Textbook 44-word expansion; round r key is words 4r..4r+3.
   task automatic expand(input logic [127:0] ck);
      logic [31:0] w [0:43];
      logic [31:0] t;
      logic [7:0]  rc;
      for (int i = 0; i < 4; i++) w[i] = ck[127 - 32*i -: 32];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rc, 24'h0};
            rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   task automatic do_async_reset();
      bus.start = 1'b0;
      bus.rk_ready = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("rst_busy", 128'(bus.busy), 128'(0));
      chk("rst_valid", 128'(bus.rk_valid), 128'(0));
      chk("rst_rk_o", bus.rk_o, 128'h0);
      chk("rst_round", 128'(bus.rk_round), 128'(0));
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Called and returns at a negedge. abort: 1 = reset during expansion, 2 = reset at round 5.
   task automatic run_seq(input logic [127:0] ckey, input int rdy_rand, input int noise, input int abort);
      int lat, exp_r, guard;
      logic stall, r;
      logic [127:0] prev_o;
      logic [3:0] prev_r;
      expand(ckey);
      for (int i = 0; i < 11; i++) got_rk[i] = 128'h0;
`ifdef KEY_SCHED_LASTKEY_EN
      bus.key_i = model_rk[10];
`else
      bus.key_i = ckey;
`endif
      bus.start = 1'b1;
      bus.rk_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      bus.start = 1'b0;
      bus.key_i = {$urandom, $urandom, $urandom, $urandom};
      chk("busy_after_start", 128'(bus.busy), 128'(1));
      lat = 0;
      while (!bus.rk_valid && lat < 40) begin
         if (abort == 1 && lat == 4) begin
            do_async_reset();
            return;
         end
         @(negedge clk);
         lat++;
      end
      chk("latency", 128'(lat), 128'(LAT));
      exp_r = 10; stall = 1'b0; guard = 0;
      prev_o = 128'h0; prev_r = 4'd0;
      while (exp_r >= 0 && guard < 600) begin
         guard++;
         chk("valid", 128'(bus.rk_valid), 128'(1));
         if (stall) begin
            chk("stall_rk_o", bus.rk_o, prev_o);
            chk("stall_round", 128'(bus.rk_round), 128'(prev_r));
         end
         if (abort == 2 && exp_r == 5) begin
            chk("abort_round", 128'(bus.rk_round), 128'(5));
            do_async_reset();
            return;
         end
         r = rdy_rand != 0 ? 1'($urandom_range(0, 1)) : 1'b1;
         bus.rk_ready = r;
         if (noise != 0) begin
            bus.start = (r && exp_r == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            bus.key_i = {$urandom, $urandom, $urandom, $urandom};
         end
         if (r) begin
            chk($sformatf("round_idx_%0d", exp_r), 128'(bus.rk_round), 128'(exp_r));
            chk($sformatf("rk_o_round_%0d", exp_r), bus.rk_o, model_rk[exp_r]);
            got_rk[exp_r] = bus.rk_o;
            exp_r--;
            stall = 1'b0;
         end else begin
            stall = 1'b1;
            prev_o = bus.rk_o;
            prev_r = bus.rk_round;
         end
         @(negedge clk);
      end
      bus.start = 1'b0;
      bus.rk_ready = 1'b0;
      chk("emit_bound", 128'(exp_r + 1), 128'(0));
      chk("done_busy", 128'(bus.busy), 128'(0));
      chk("done_valid", 128'(bus.rk_valid), 128'(0));
      chk("done_rk_o", bus.rk_o, 128'h0);
      if (noise != 0) begin
         @(negedge clk);
         chk("no_late_start", 128'(bus.busy), 128'(0));
      end
   endtask

   initial begin
      passed = 0;
      total = 0;
      bus.start = 1'b0;
      bus.key_i = 128'h0;
      bus.rk_ready = 1'b0;
      build_sbox();

      vecs[0] = '{K1, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
      vecs[1] = '{K1, 9,  128'hac7766f319fadc2128d12941575c006e};
      vecs[2] = '{K1, 1,  128'ha0fafe1788542cb123a339392a6c7605};
      vecs[3] = '{K1, 0,  K1};
      vecs[4] = '{K2, 10, 128'h13111d7fe3944a17f307a78b4d2b30c5};

      repeat (3) @(negedge clk);
      chk("reset_busy", 128'(bus.busy), 128'(0));
      chk("reset_valid", 128'(bus.rk_valid), 128'(0));
      chk("reset_rk_o", bus.rk_o, 128'h0);
      chk("reset_round", 128'(bus.rk_round), 128'(0));
      rst = 1'b0;
      @(negedge clk);
      chk("idle_busy", 128'(bus.busy), 128'(0));

      for (int i = 0; i < 5; i++) begin
         run_seq(vecs[i].key, 0, 0, 0);
         chk($sformatf("vec%0d_round%0d", i, vecs[i].round), got_rk[vecs[i].round], vecs[i].exp);
         @(negedge clk);
      end

      run_seq(K1, 1, 0, 0);
      chk("rand_ready_r0", got_rk[0], K1);
      @(negedge clk);
      run_seq(K1, 1, 1, 0);
      chk("noise_r10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      @(negedge clk);

      run_seq(K1, 0, 0, 1);
      run_seq(K1, 0, 0, 0);
      chk("after_rst1_r9", got_rk[9], 128'hac7766f319fadc2128d12941575c006e);
      @(negedge clk);
      run_seq(K1, 1, 0, 2);
      run_seq(K1, 0, 0, 0);
      chk("after_rst2_r0", got_rk[0], K1);

      run_seq(K2, 0, 0, 0);
      run_seq(K2, 0, 0, 0);
      chk("b2b_r10", got_rk[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
      run_seq(K1, 1, 0, 0);
      chk("b2b_k1_r0", got_rk[0], K1);

      for (int n = 0; n < 6; n++) begin
         @(negedge clk);
         run_seq({$urandom, $urandom, $urandom, $urandom}, 1, int'($urandom_range(0, 1)), 0);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
